riscv_lsu: RTL and testbench

- Load/store unit between the execute stage and the data-memory interface block.
- Accepts one memory request at a time and computes the effective address as base + offset.
- Checks size and alignment. Stores are driven for exactly one cycle; loads are held until the memory interface signals data ready.
- Returns a registered response (load data or exception code) to writeback over a valid/ready handshake.

---
 rtl/riscv_lsu.sv | 175 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// ============================================================================
// Module   : riscv_lsu
// Purpose  : Load/store unit: address generation, size/alignment checking,
//            single-cycle store strobe, held load request, registered response.
//            Optional load timeout enabled by defining LSU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_is_store_in,
    input  logic [31:0] req_base_in,
    input  logic [31:0] req_offset_in,
    input  logic [2:0]  req_size_in,
    input  logic [31:0] req_store_data_in,
    input  logic [4:0]  req_rd_in,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_data_out,
    output logic [2:0]  mem_size_out,
    output logic        mem_write_enable_out,
    output logic        mem_read_enable_out,
    input  logic        mem_data_ready_in,
    input  logic [31:0] mem_data_in,
    output logic        resp_valid_out,
    input  logic        resp_ready_in,
    output logic [4:0]  resp_rd_out,
    output logic [31:0] resp_data_out,
    output logic [1:0]  resp_exc_out,
    output logic [31:0] resp_addr_out
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STORE     = 2'd1,
        ST_LOAD_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    localparam logic [1:0] c_EXC_OK       = 2'b00;
    localparam logic [1:0] c_EXC_MISALIGN = 2'b01;
    localparam logic [1:0] c_EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] c_EXC_TIMEOUT  = 2'b11;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_size;
    logic [4:0]  r_rd;
    logic [1:0]  r_exc;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic [31:0] w_eff_addr;
    logic        w_size_legal;
    logic        w_misalign;
    logic [1:0]  w_exc;
    logic        w_load_done;
    logic        w_timeout;

    assign w_accept   = req_valid_in && (r_state == ST_IDLE);
    assign w_eff_addr = req_base_in + req_offset_in;

    always_comb begin
        w_size_legal = 1'b0;
        case (req_size_in)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_size_legal = 1'b1;
            default:                                w_size_legal = 1'b0;
        endcase
    end

    // Only evaluated for legal sizes: low bits 01 = H/HU, 10 = W.
    assign w_misalign = ((req_size_in[1:0] == 2'b01) && w_eff_addr[0]) ||
                        ((req_size_in[1:0] == 2'b10) && (w_eff_addr[1:0] != 2'b00));

    assign w_exc = !w_size_legal ? c_EXC_ILLEGAL  :
                   w_misalign    ? c_EXC_MISALIGN : c_EXC_OK;

    assign w_load_done = (r_state == ST_LOAD_WAIT) && mem_data_ready_in;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle without data.
    assign w_timeout = (r_state == ST_LOAD_WAIT) && !mem_data_ready_in &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_LOAD_WAIT) && !mem_data_ready_in) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_exc != c_EXC_OK)    w_state_nxt = ST_RESP;
                    else if (req_is_store_in) w_state_nxt = ST_STORE;
                    else                      w_state_nxt = ST_LOAD_WAIT;
                end
            end
            ST_STORE:     w_state_nxt = ST_RESP;
            ST_LOAD_WAIT: if (w_load_done || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:      if (resp_ready_in) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_rd    <= '0;
            r_exc   <= c_EXC_OK;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= w_eff_addr;
                r_size  <= req_size_in;
                r_wdata <= req_store_data_in;
                r_rd    <= req_is_store_in ? 5'd0 : req_rd_in;
                r_exc   <= w_exc;
                r_rdata <= '0;
            end
            if (w_load_done) begin
                r_rdata <= mem_data_in;
            end else if (w_timeout) begin
                r_exc   <= c_EXC_TIMEOUT;
            end
        end
    end

    // Enables decode straight from state so an async reset drops them at once.
    assign req_ready_out        = (r_state == ST_IDLE);
    assign mem_write_enable_out = (r_state == ST_STORE);
    assign mem_read_enable_out  = (r_state == ST_LOAD_WAIT);
    assign mem_addr_out         = r_addr;
    assign mem_data_out         = r_wdata;
    assign mem_size_out         = r_size;

    assign resp_valid_out = (r_state == ST_RESP);
    assign resp_rd_out    = r_rd;
    assign resp_data_out  = r_rdata;
    assign resp_exc_out   = r_exc;
    assign resp_addr_out  = r_addr;

endmodule

`default_nettype wire

// File: tb/tb_riscv_lsu.sv
// ============================================================================
// Module   : tb_riscv_lsu
// Purpose  : Directed self-checking bench for riscv_lsu (timeout case only
//            when LSU_TIMEOUT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_lsu;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_is_store_in;
    logic [31:0] req_base_in;
    logic [31:0] req_offset_in;
    logic [2:0]  req_size_in;
    logic [31:0] req_store_data_in;
    logic [4:0]  req_rd_in;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic [2:0]  mem_size_out;
    logic        mem_write_enable_out;
    logic        mem_read_enable_out;
    logic        mem_data_ready_in;
    logic [31:0] mem_data_in;
    logic        resp_valid_out;
    logic        resp_ready_in;
    logic [4:0]  resp_rd_out;
    logic [31:0] resp_data_out;
    logic [1:0]  resp_exc_out;
    logic [31:0] resp_addr_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    riscv_lsu #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk_in               (clk_in),
        .rst_n_in             (rst_n_in),
        .req_valid_in         (req_valid_in),
        .req_ready_out        (req_ready_out),
        .req_is_store_in      (req_is_store_in),
        .req_base_in          (req_base_in),
        .req_offset_in        (req_offset_in),
        .req_size_in          (req_size_in),
        .req_store_data_in    (req_store_data_in),
        .req_rd_in            (req_rd_in),
        .mem_addr_out         (mem_addr_out),
        .mem_data_out         (mem_data_out),
        .mem_size_out         (mem_size_out),
        .mem_write_enable_out (mem_write_enable_out),
        .mem_read_enable_out  (mem_read_enable_out),
        .mem_data_ready_in    (mem_data_ready_in),
        .mem_data_in          (mem_data_in),
        .resp_valid_out       (resp_valid_out),
        .resp_ready_in        (resp_ready_in),
        .resp_rd_out          (resp_rd_out),
        .resp_data_out        (resp_data_out),
        .resp_exc_out         (resp_exc_out),
        .resp_addr_out        (resp_addr_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the LSU idle; returns at the negedge after the accept edge.
    task automatic issue(input logic st, input logic [31:0] base, input logic [31:0] off,
                         input logic [2:0] size, input logic [31:0] data, input logic [4:0] rd);
        chk("req_ready_before", {31'd0, req_ready_out}, 32'd1);
        req_valid_in      = 1'b1;
        req_is_store_in   = st;
        req_base_in       = base;
        req_offset_in     = off;
        req_size_in       = size;
        req_store_data_in = data;
        req_rd_in         = rd;
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid_in      = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic [4:0] rd, input logic [31:0] data,
                            input logic [1:0] exc, input logic [31:0] addr);
        chk({tag, "_valid"}, {31'd0, resp_valid_out}, 32'd1);
        chk({tag, "_rd"},    {27'd0, resp_rd_out}, {27'd0, rd});
        chk({tag, "_data"},  resp_data_out, data);
        chk({tag, "_exc"},   {30'd0, resp_exc_out}, {30'd0, exc});
        chk({tag, "_addr"},  resp_addr_out, addr);
        chk({tag, "_en"},    {30'd0, mem_write_enable_out, mem_read_enable_out}, 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, {31'd0, req_ready_out}, 32'd1);
        chk({tag, "_rv"},    {31'd0, resp_valid_out}, 32'd0);
        chk({tag, "_en"},    {30'd0, mem_write_enable_out, mem_read_enable_out}, 32'd0);
    endtask

    initial begin
        rst_n_in          = 1'b0;
        req_valid_in      = 1'b0;
        req_is_store_in   = 1'b0;
        req_base_in       = '0;
        req_offset_in     = '0;
        req_size_in       = '0;
        req_store_data_in = '0;
        req_rd_in         = '0;
        mem_data_ready_in = 1'b0;
        mem_data_in       = '0;
        resp_ready_in     = 1'b1;

        repeat (2) @(negedge clk_in);
        chk_idle("rst");
        chk("rst_addr",  mem_addr_out, 32'd0);
        chk("rst_rdata", resp_data_out, 32'd0);
        chk("rst_exc",   {30'd0, resp_exc_out}, 32'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Load word with a three-cycle memory latency.
        issue(1'b0, 32'h0000_1000, 32'h4, 3'b010, 32'h0, 5'd9);
        chk("lw_ren0",  {31'd0, mem_read_enable_out}, 32'd1);
        chk("lw_wen0",  {31'd0, mem_write_enable_out}, 32'd0);
        chk("lw_addr0", mem_addr_out, 32'h0000_1004);
        chk("lw_busy",  {31'd0, req_ready_out}, 32'd0);
        @(negedge clk_in);
        chk("lw_ren1",  {31'd0, mem_read_enable_out}, 32'd1);
        chk("lw_addr1", mem_addr_out, 32'h0000_1004);
        chk("lw_size1", {29'd0, mem_size_out}, 32'd2);
        @(negedge clk_in);
        chk("lw_ren2",  {31'd0, mem_read_enable_out}, 32'd1);
        mem_data_ready_in = 1'b1;
        mem_data_in       = 32'hDEAD_BEEF;
        @(negedge clk_in);
        mem_data_ready_in = 1'b0;
        mem_data_in       = 32'h0;
        chk_resp("lw", 5'd9, 32'hDEAD_BEEF, 2'b00, 32'h0000_1004);
        @(negedge clk_in);
        chk_idle("lw_done");

        // Store byte: one-cycle strobe, rd reported as 0.
        issue(1'b1, 32'h0000_2003, 32'h0, 3'b000, 32'h0000_00AB, 5'd7);
        chk("sb_wen",  {31'd0, mem_write_enable_out}, 32'd1);
        chk("sb_ren",  {31'd0, mem_read_enable_out}, 32'd0);
        chk("sb_addr", mem_addr_out, 32'h0000_2003);
        chk("sb_data", mem_data_out, 32'h0000_00AB);
        chk("sb_size", {29'd0, mem_size_out}, 32'd0);
        @(negedge clk_in);
        chk_resp("sb", 5'd0, 32'h0, 2'b00, 32'h0000_2003);
        @(negedge clk_in);
        chk_idle("sb_done");

        // Misaligned word load.
        issue(1'b0, 32'h0000_1000, 32'h2, 3'b010, 32'h0, 5'd5);
        chk_resp("lw_mis", 5'd5, 32'h0, 2'b01, 32'h0000_1002);
        @(negedge clk_in);
        chk_idle("lw_mis_done");

        // Illegal size beats misalignment.
        issue(1'b0, 32'h0000_1000, 32'h1, 3'b011, 32'h0, 5'd6);
        chk_resp("ill", 5'd6, 32'h0, 2'b10, 32'h0000_1001);
        @(negedge clk_in);
        chk_idle("ill_done");

        // Misaligned halfword store.
        issue(1'b1, 32'h0000_3000, 32'h1, 3'b001, 32'h1234, 5'd3);
        chk_resp("sh_mis", 5'd0, 32'h0, 2'b01, 32'h0000_3001);
        @(negedge clk_in);
        chk_idle("sh_mis_done");

        // Address wrap plus response backpressure; stray data ready is ignored.
        issue(1'b1, 32'hFFFF_FFFC, 32'h8, 3'b010, 32'hCAFE_F00D, 5'd4);
        chk("wrap_addr", mem_addr_out, 32'h0000_0004);
        chk("wrap_wen",  {31'd0, mem_write_enable_out}, 32'd1);
        resp_ready_in     = 1'b0;
        mem_data_ready_in = 1'b1;
        mem_data_in       = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk_resp("bp", 5'd0, 32'h0, 2'b00, 32'h0000_0004);
            chk("bp_busy", {31'd0, req_ready_out}, 32'd0);
        end
        mem_data_ready_in = 1'b0;
        resp_ready_in     = 1'b1;
        @(negedge clk_in);
        chk_idle("bp_done");

        // Unsigned halfword load with data already ready: single wait cycle.
        mem_data_ready_in = 1'b1;
        mem_data_in       = 32'h0000_BEEF;
        issue(1'b0, 32'h0000_1000, 32'h2, 3'b101, 32'h0, 5'd12);
        chk("lhu_ren", {31'd0, mem_read_enable_out}, 32'd1);
        @(negedge clk_in);
        mem_data_ready_in = 1'b0;
        chk_resp("lhu", 5'd12, 32'h0000_BEEF, 2'b00, 32'h0000_1002);
        @(negedge clk_in);
        chk_idle("lhu_done");

        // Asynchronous reset in the middle of a load.
        issue(1'b0, 32'h0000_4000, 32'h0, 3'b010, 32'h0, 5'd1);
        chk("rm_ren_pre", {31'd0, mem_read_enable_out}, 32'd1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("rm_ren",   {31'd0, mem_read_enable_out}, 32'd0);
        chk("rm_rv",    {31'd0, resp_valid_out}, 32'd0);
        chk("rm_addr",  mem_addr_out, 32'd0);
        chk("rm_ready", {31'd0, req_ready_out}, 32'd1);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk_idle("rm_after");

`ifdef LSU_TIMEOUT_EN
        issue(1'b0, 32'h0000_5000, 32'h8, 3'b010, 32'h0, 5'd17);
        for (int i = 0; i < 16; i++) begin
            chk("tmo_ren", {31'd0, mem_read_enable_out}, 32'd1);
            @(negedge clk_in);
        end
        chk_resp("tmo", 5'd17, 32'h0, 2'b11, 32'h0000_5008);
        @(negedge clk_in);
        chk_idle("tmo_done");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
